mdio_link_poller: RTL and testbench
===================================

MDIO_LINK_POLLER -- requirements
Module: mdio_link_poller

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- P_AXI_ADDR_WIDTH, 13, AXI command address width.
- P_AXI_DATA_WIDTH, 32, AXI command data width.
- P_PHY_ADDR, 5'd0, target PHY address.
- P_POLL_INTERVAL, 100000, idle clk cycles between poll sequences (>=1).
- P_BUSY_TIMEOUT, 4096, max clk cycles in the MDIO-busy poll loop.

REQ-002 Ports (name, direction, width, meaning), one per line:
- clk, in, 1, sole clock.
- rst, in, 1, synchronous active-high reset.
- enable, in, 1, run periodic polling.
- do_axi_write, out, 1, one-cycle write request to axi_eth.
- axi_write_addr, out, P_AXI_ADDR_WIDTH, write address.
- axi_write_data, out, P_AXI_DATA_WIDTH, write data.
- write_done, in, 1, write complete.
- do_axi_read, out, 1, one-cycle read request.
- axi_read_addr, out, P_AXI_ADDR_WIDTH, read address.
- axi_read_data, in, P_AXI_DATA_WIDTH, read result, valid while read_done=1.
- read_done, in, 1, read complete.
- phy_status, out, 16, last PHY register 1 value.
- link_up, out, 1, phy_status[2].
- autoneg_done, out, 1, phy_status[5].
- status_valid, out, 1, one-cycle pulse on each phy_status update.
- link_change, out, 1, one-cycle pulse when link_up toggles.
- err_timeout, out, 1, sticky busy-timeout flag.
- busy, out, 1, high in every state except IDLE and INTERVAL.

Function
REQ-003 Register map: MDIO_ADDR=0x07E4, MDIO_WR=0x07E8, MDIO_RD=0x07EC, MDIO_CTRL=0x07F0.
REQ-004 FSM states: IDLE, WR_ADDR, W_WR_ADDR, WR_CTRL, W_WR_CTRL, RD_CTRL, W_RD_CTRL, RD_DATA, W_RD_DATA, UPDATE, INTERVAL.
REQ-005 IDLE goes to WR_ADDR in the cycle after enable is sampled high.
REQ-006 WR_ADDR drives do_axi_write=1 for exactly one cycle, addr=MDIO_ADDR, data={21'b0, 1'b1, P_PHY_ADDR, 5'd1} (0x401 for PHY 0).
REQ-007 WR_CTRL drives do_axi_write=1 for exactly one cycle, addr=MDIO_CTRL, data=0x9 (enable + start).
REQ-008 RD_CTRL drives do_axi_read=1 for exactly one cycle, addr=MDIO_CTRL.
REQ-009 RD_DATA drives do_axi_read=1 for exactly one cycle, addr=MDIO_RD.
REQ-010 Each request state advances to its W_* state. The W_* state waits for the matching done signal, sampled high in any cycle after the request cycle.
REQ-011 Address and data outputs shall remain stable from the request cycle until the matching done signal is sampled.
REQ-012 write_done/read_done seen outside the matching W_* state, or in the request cycle itself, shall be ignored.
REQ-013 W_RD_CTRL, on read_done:
- axi_read_data[0]=1 (MDIO busy) -> RD_CTRL.
- otherwise -> RD_DATA.
REQ-014 The busy-poll cycle counter starts at 0 on entry to RD_CTRL from W_WR_CTRL and increments every cycle until RD_DATA is entered. When it reaches P_BUSY_TIMEOUT:
- err_timeout is set;
- status outputs are left unchanged and no pulse is generated;
- the FSM goes to INTERVAL.
REQ-015 W_RD_DATA, on read_done:
- captures axi_read_data[15:0] into phy_status;
- goes to UPDATE.
REQ-016 UPDATE lasts one cycle:
- status_valid=1;
- link_up/autoneg_done are registered from the new phy_status and visible in this cycle;
- link_change=1 if the new link_up differs from the previous link_up;
- then -> INTERVAL.
REQ-017 INTERVAL counts P_POLL_INTERVAL cycles, then:
- enable=1 -> WR_ADDR;
- enable=0 -> IDLE.
REQ-018 If enable deasserts mid-sequence, the current sequence completes through UPDATE or timeout, then INTERVAL runs, then the FSM enters IDLE.
REQ-019 do_axi_write and do_axi_read shall never be high in the same cycle, and at most one transaction is outstanding.

Reset
REQ-020 rst=1 at a clk edge forces IDLE next cycle, clears all counters, and sets every output to 0: requests, addresses, data, phy_status, link_up, autoneg_done, status_valid, link_change, err_timeout, busy.
REQ-021 Reset mid-transaction abandons the transaction, and any later done pulse from it is ignored per REQ-012.

Verification
REQ-022 The bench shall cover these directed scenarios:
- Basic poll: enable=1, done returned 2 cycles after each request, CTRL read returns 0x0, RD returns 0x782D -> writes 0x401@0x7E4 then 0x9@0x7F0, reads 0x7F0 then 0x7EC; phy_status=0x782D, link_up=1, autoneg_done=1, status_valid pulse, link_change pulse.
- Busy retry: CTRL read returns 0x1 three times, then 0x0 -> exactly four MDIO_CTRL reads, then one MDIO_RD read.
- Timeout: P_BUSY_TIMEOUT=64, CTRL always 0x1 -> err_timeout=1 sticky, no status_valid, next sequence starts after P_POLL_INTERVAL cycles.
- Link drop: second poll returns 0x7849 -> link_up=0, autoneg_done=0, link_change pulse; a third poll returning 0x7849 produces no link_change.
- Enable drop: enable=0 during W_WR_CTRL -> sequence completes, INTERVAL runs, IDLE entered, no further requests issued.
- Reset mid-op: rst=1 during W_RD_DATA, late read_done after reset -> all outputs 0, phy_status stays 0, FSM in IDLE.

Source files
------------

// File: rtl/mdio_link_poller.sv
`default_nettype none
// ============================================================================
// Module   : mdio_link_poller
// Purpose  : Periodically reads PHY register 1 (basic status) through the
//            axi_eth MDIO command registers and publishes link state.
//            Each poll: write MDIO_ADDR, write MDIO_CTRL (start), poll
//            MDIO_CTRL until not busy, read MDIO_RD, update status.
// Ports    : clk/rst           - clock, synchronous active-high reset
//            enable            - run periodic polling
//            do_axi_write/addr/data, write_done - write command channel
//            do_axi_read/addr, axi_read_data, read_done - read command channel
//            phy_status, link_up, autoneg_done - last PHY status snapshot
//            status_valid, link_change         - one-cycle update pulses
//            err_timeout       - sticky MDIO busy-poll timeout
//            busy              - a poll sequence is in progress
// Revision : 1.0 - initial release
// ============================================================================
module mdio_link_poller #(
    parameter int         P_AXI_ADDR_WIDTH = 13,
    parameter int         P_AXI_DATA_WIDTH = 32,
    parameter logic [4:0] P_PHY_ADDR       = 5'd0,
    parameter int         P_POLL_INTERVAL  = 100000,
    parameter int         P_BUSY_TIMEOUT   = 4096
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        enable,
    output logic                        do_axi_write,
    output logic [P_AXI_ADDR_WIDTH-1:0] axi_write_addr,
    output logic [P_AXI_DATA_WIDTH-1:0] axi_write_data,
    input  logic                        write_done,
    output logic                        do_axi_read,
    output logic [P_AXI_ADDR_WIDTH-1:0] axi_read_addr,
    input  logic [P_AXI_DATA_WIDTH-1:0] axi_read_data,
    input  logic                        read_done,
    output logic [15:0]                 phy_status,
    output logic                        link_up,
    output logic                        autoneg_done,
    output logic                        status_valid,
    output logic                        link_change,
    output logic                        err_timeout,
    output logic                        busy
);

    // ------------------------------------------------------------------
    // Register map and command words
    // ------------------------------------------------------------------
    localparam logic [P_AXI_ADDR_WIDTH-1:0] c_MDIO_ADDR = P_AXI_ADDR_WIDTH'(16'h07E4);
    localparam logic [P_AXI_ADDR_WIDTH-1:0] c_MDIO_RD   = P_AXI_ADDR_WIDTH'(16'h07EC);
    localparam logic [P_AXI_ADDR_WIDTH-1:0] c_MDIO_CTRL = P_AXI_ADDR_WIDTH'(16'h07F0);

    // Read opcode flag, PHY address, register 1 (basic status)
    localparam logic [P_AXI_DATA_WIDTH-1:0] c_ADDR_WORD = P_AXI_DATA_WIDTH'({1'b1, P_PHY_ADDR, 5'd1});
    // MDIO enable + start
    localparam logic [P_AXI_DATA_WIDTH-1:0] c_CTRL_WORD = P_AXI_DATA_WIDTH'(4'h9);

    localparam int                  c_BUSY_CW    = $clog2(P_BUSY_TIMEOUT + 1);
    localparam logic [c_BUSY_CW-1:0] c_BUSY_LIMIT = c_BUSY_CW'(P_BUSY_TIMEOUT);
    localparam int                  c_INT_CW     = $clog2(P_POLL_INTERVAL + 1);
    localparam logic [c_INT_CW-1:0]  c_INT_LAST   = c_INT_CW'(P_POLL_INTERVAL - 1);

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        WR_ADDR   = 4'd1,
        W_WR_ADDR = 4'd2,
        WR_CTRL   = 4'd3,
        W_WR_CTRL = 4'd4,
        RD_CTRL   = 4'd5,
        W_RD_CTRL = 4'd6,
        RD_DATA   = 4'd7,
        W_RD_DATA = 4'd8,
        UPDATE    = 4'd9,
        INTERVAL  = 4'd10
    } state_t;

    state_t                      r_state;
    state_t                      w_state_next;
    logic [c_BUSY_CW-1:0]        r_busy_cnt;
    logic [c_INT_CW-1:0]         r_int_cnt;
    logic                        w_busy_tmo;
    logic                        w_int_last;
    logic                        w_capture;

    logic [P_AXI_ADDR_WIDTH-1:0] r_wr_addr;
    logic [P_AXI_DATA_WIDTH-1:0] r_wr_data;
    logic [P_AXI_ADDR_WIDTH-1:0] r_rd_addr;
    logic [15:0]                 r_phy_status;
    logic                        r_link_up;
    logic                        r_autoneg_done;
    logic                        r_status_valid;
    logic                        r_link_change;
    logic                        r_err_timeout;

    // The busy-poll window covers both the CTRL request and its wait state.
    assign w_busy_tmo = ((r_state == RD_CTRL) || (r_state == W_RD_CTRL)) &&
                        (r_busy_cnt == c_BUSY_LIMIT);
    assign w_int_last = (r_int_cnt == c_INT_LAST);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next state and request outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_capture    = 1'b0;
        do_axi_write = 1'b0;
        do_axi_read  = 1'b0;
        busy         = 1'b1;
        case (r_state)
            IDLE: begin
                busy = 1'b0;
                if (enable) begin
                    w_state_next = WR_ADDR;
                end
            end
            WR_ADDR: begin
                do_axi_write = 1'b1;
                w_state_next = W_WR_ADDR;
            end
            W_WR_ADDR: begin
                if (write_done) begin
                    w_state_next = WR_CTRL;
                end
            end
            WR_CTRL: begin
                do_axi_write = 1'b1;
                w_state_next = W_WR_CTRL;
            end
            W_WR_CTRL: begin
                if (write_done) begin
                    w_state_next = RD_CTRL;
                end
            end
            RD_CTRL: begin
                // No new read is launched once the busy budget is spent.
                if (w_busy_tmo) begin
                    w_state_next = INTERVAL;
                end else begin
                    do_axi_read  = 1'b1;
                    w_state_next = W_RD_CTRL;
                end
            end
            W_RD_CTRL: begin
                if (w_busy_tmo) begin
                    w_state_next = INTERVAL;
                end else if (read_done) begin
                    w_state_next = axi_read_data[0] ? RD_CTRL : RD_DATA;
                end
            end
            RD_DATA: begin
                do_axi_read  = 1'b1;
                w_state_next = W_RD_DATA;
            end
            W_RD_DATA: begin
                if (read_done) begin
                    w_capture    = 1'b1;
                    w_state_next = UPDATE;
                end
            end
            UPDATE: begin
                w_state_next = INTERVAL;
            end
            INTERVAL: begin
                busy = 1'b0;
                if (w_int_last) begin
                    w_state_next = enable ? WR_ADDR : IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy_cnt <= '0;
            r_int_cnt  <= '0;
        end else begin
            // Held at zero while the start command completes so the first
            // RD_CTRL cycle counts as zero.
            if (r_state == W_WR_CTRL) begin
                r_busy_cnt <= '0;
            end else if ((r_state == RD_CTRL) || (r_state == W_RD_CTRL)) begin
                r_busy_cnt <= r_busy_cnt + c_BUSY_CW'(1);
            end

            if ((r_state == INTERVAL) && !w_int_last) begin
                r_int_cnt <= r_int_cnt + c_INT_CW'(1);
            end else begin
                r_int_cnt <= '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Command address/data: loaded on entry to a request state and held
    // through the following wait state.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_rd_addr <= '0;
        end else begin
            case (w_state_next)
                WR_ADDR: begin
                    r_wr_addr <= c_MDIO_ADDR;
                    r_wr_data <= c_ADDR_WORD;
                end
                WR_CTRL: begin
                    r_wr_addr <= c_MDIO_CTRL;
                    r_wr_data <= c_CTRL_WORD;
                end
                RD_CTRL: r_rd_addr <= c_MDIO_CTRL;
                RD_DATA: r_rd_addr <= c_MDIO_RD;
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Status capture: everything lands together so UPDATE sees the new
    // snapshot, its pulse and the link edge in the same cycle.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_phy_status   <= '0;
            r_link_up      <= 1'b0;
            r_autoneg_done <= 1'b0;
            r_status_valid <= 1'b0;
            r_link_change  <= 1'b0;
            r_err_timeout  <= 1'b0;
        end else begin
            r_status_valid <= w_capture;
            r_link_change  <= w_capture && (axi_read_data[2] != r_link_up);
            if (w_capture) begin
                r_phy_status   <= axi_read_data[15:0];
                r_link_up      <= axi_read_data[2];
                r_autoneg_done <= axi_read_data[5];
            end
            if (w_busy_tmo) begin
                r_err_timeout <= 1'b1;
            end
        end
    end

    generate
        if (P_AXI_DATA_WIDTH > 16) begin : g_unused_hi
            logic w_unused_hi;
            assign w_unused_hi = ^axi_read_data[P_AXI_DATA_WIDTH-1:16];
        end
    endgenerate

    assign axi_write_addr = r_wr_addr;
    assign axi_write_data = r_wr_data;
    assign axi_read_addr  = r_rd_addr;
    assign phy_status     = r_phy_status;
    assign link_up        = r_link_up;
    assign autoneg_done   = r_autoneg_done;
    assign status_valid   = r_status_valid;
    assign link_change    = r_link_change;
    assign err_timeout    = r_err_timeout;

endmodule
`default_nettype wire

// File: tb/tb_mdio_link_poller.sv
`default_nettype none
// ============================================================================
// Module   : tb_mdio_link_poller
// Purpose  : Self-checking bench for mdio_link_poller. An axi_eth responder
//            answers each command two cycles later; expected commands and
//            status updates are queued by the stimulus and compared when the
//            DUT produces them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mdio_link_poller;

    localparam int AW   = 13;
    localparam int DW   = 32;
    localparam int POLL = 16;
    localparam int TMO  = 64;

    localparam logic [AW-1:0] A_ADDR = 13'h07E4;
    localparam logic [AW-1:0] A_RD   = 13'h07EC;
    localparam logic [AW-1:0] A_CTRL = 13'h07F0;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic          do_axi_write;
    logic [AW-1:0] axi_write_addr;
    logic [DW-1:0] axi_write_data;
    logic          write_done;
    logic          do_axi_read;
    logic [AW-1:0] axi_read_addr;
    logic [DW-1:0] axi_read_data;
    logic          read_done;
    logic [15:0]   phy_status;
    logic          link_up;
    logic          autoneg_done;
    logic          status_valid;
    logic          link_change;
    logic          err_timeout;
    logic          busy;

    mdio_link_poller #(
        .P_AXI_ADDR_WIDTH (AW),
        .P_AXI_DATA_WIDTH (DW),
        .P_PHY_ADDR       (5'd0),
        .P_POLL_INTERVAL  (POLL),
        .P_BUSY_TIMEOUT   (TMO)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .enable         (enable),
        .do_axi_write   (do_axi_write),
        .axi_write_addr (axi_write_addr),
        .axi_write_data (axi_write_data),
        .write_done     (write_done),
        .do_axi_read    (do_axi_read),
        .axi_read_addr  (axi_read_addr),
        .axi_read_data  (axi_read_data),
        .read_done      (read_done),
        .phy_status     (phy_status),
        .link_up        (link_up),
        .autoneg_done   (autoneg_done),
        .status_valid   (status_valid),
        .link_change    (link_change),
        .err_timeout    (err_timeout),
        .busy           (busy)
    );

    initial forever #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Scoreboards and model
    // ------------------------------------------------------------------
    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } txn_t;

    typedef struct {
        logic [15:0] phy;
        logic        link;
        logic        an;
        logic        chg;
    } sts_t;

    txn_t exp_txn_q[$];
    sts_t exp_sts_q[$];
    logic model_link = 1'b0;

    // Responder controls
    int          ctrl_busy_left   = 0;
    bit          ctrl_always_busy = 1'b0;
    bit          ctrl_wild        = 1'b0;
    logic [15:0] rd_value         = 16'h0;
    int          rd_delay         = 2;
    int          n_ctrl_rd        = 0;
    int          n_data_rd        = 0;
    int          n_req            = 0;
    int          n_sts            = 0;

    task automatic push_txn(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        txn_t t;
        t.wr = wr; t.addr = a; t.data = d;
        exp_txn_q.push_back(t);
    endtask

    task automatic push_txns(input int n_busy, input logic [15:0] rd_val);
        push_txn(1'b1, A_ADDR, 32'h0000_0401);
        push_txn(1'b1, A_CTRL, 32'h0000_0009);
        for (int i = 0; i <= n_busy; i++) push_txn(1'b0, A_CTRL, '0);
        push_txn(1'b0, A_RD, '0);
        ctrl_busy_left = n_busy;
        rd_value       = rd_val;
    endtask

    task automatic push_status(input logic [15:0] v);
        sts_t s;
        s.phy  = v;
        s.link = v[2];
        s.an   = v[5];
        s.chg  = (v[2] != model_link);
        model_link = v[2];
        exp_sts_q.push_back(s);
    endtask

    task automatic wait_status(input int n);
        int k = 0;
        while (n_sts < n && k < 400) begin
            @(negedge clk);
            k++;
        end
        chk("status_arrived", n_sts, n);
    endtask

    task automatic check_all_zero(input string p);
        chk({p, "_do_wr"},   do_axi_write, 0);
        chk({p, "_do_rd"},   do_axi_read, 0);
        chk({p, "_wr_addr"}, axi_write_addr, 0);
        chk({p, "_wr_data"}, axi_write_data, 0);
        chk({p, "_rd_addr"}, axi_read_addr, 0);
        chk({p, "_phy"},     phy_status, 0);
        chk({p, "_link"},    link_up, 0);
        chk({p, "_an"},      autoneg_done, 0);
        chk({p, "_valid"},   status_valid, 0);
        chk({p, "_chg"},     link_change, 0);
        chk({p, "_tmo"},     err_timeout, 0);
        chk({p, "_busy"},    busy, 0);
    endtask

    // ------------------------------------------------------------------
    // axi_eth responder: checks each command against the expected queue
    // and returns done after a fixed latency.
    // ------------------------------------------------------------------
    initial begin
        int            pend     = 0;
        logic          pend_wr  = 1'b0;
        logic [AW-1:0] pend_addr = '0;
        logic [DW-1:0] pend_wdat = '0;
        logic [DW-1:0] pend_data = '0;
        bit            just_req = 1'b0;
        txn_t          e;
        write_done    = 1'b0;
        read_done     = 1'b0;
        axi_read_data = 32'hDEAD_BEEF;
        forever begin
            @(negedge clk);
            write_done    = 1'b0;
            read_done     = 1'b0;
            axi_read_data = 32'hDEAD_BEEF;
            if (just_req) begin
                chk("req_one_cycle", {do_axi_write, do_axi_read}, 0);
                just_req = 1'b0;
            end
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    if (busy) begin
                        if (pend_wr) begin
                            chk("wr_addr_stable", axi_write_addr, pend_addr);
                            chk("wr_data_stable", axi_write_data, pend_wdat);
                        end else begin
                            chk("rd_addr_stable", axi_read_addr, pend_addr);
                        end
                    end
                    if (pend_wr) begin
                        write_done = 1'b1;
                    end else begin
                        read_done     = 1'b1;
                        axi_read_data = pend_data;
                    end
                end
            end
            if (do_axi_write || do_axi_read) begin
                n_req++;
                chk("wr_rd_exclusive", do_axi_write & do_axi_read, 0);
                chk("one_outstanding", pend, 0);
                pend_wr   = do_axi_write;
                pend_addr = do_axi_write ? axi_write_addr : axi_read_addr;
                pend_wdat = axi_write_data;
                if (!(ctrl_wild && do_axi_read && axi_read_addr == A_CTRL)) begin
                    if (exp_txn_q.size() == 0) begin
                        chk("unexpected_req", {do_axi_write, do_axi_read}, 0);
                    end else begin
                        e = exp_txn_q.pop_front();
                        chk("req_kind", do_axi_write, e.wr);
                        chk("req_addr", pend_addr, e.addr);
                        if (e.wr) chk("req_wdata", axi_write_data, e.data);
                    end
                end
                pend = 2;
                if (do_axi_read) begin
                    if (axi_read_addr == A_CTRL) begin
                        n_ctrl_rd++;
                        pend_data = (ctrl_always_busy || ctrl_busy_left > 0) ?
                                    32'hFFFE_0001 : 32'hFFFE_0000;
                        if (ctrl_busy_left > 0) ctrl_busy_left--;
                    end else begin
                        n_data_rd++;
                        pend_data = {16'hA5A5, rd_value};
                        pend      = rd_delay;
                    end
                end
                just_req = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Status monitor
    // ------------------------------------------------------------------
    initial begin
        sts_t s;
        forever begin
            @(negedge clk);
            if (status_valid) begin
                n_sts++;
                if (exp_sts_q.size() == 0) begin
                    chk("unexpected_status", status_valid, 0);
                end else begin
                    s = exp_sts_q.pop_front();
                    chk("phy_status", phy_status, s.phy);
                    chk("link_up", link_up, s.link);
                    chk("autoneg_done", autoneg_done, s.an);
                    chk("link_change", link_change, s.chg);
                end
            end else if (link_change) begin
                chk("change_without_valid", link_change, 0);
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        int c0, d0, r0, k;
        rst    = 1'b1;
        enable = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        repeat (10) @(negedge clk);
        chk("idle_no_req", n_req, 0);
        chk("idle_busy", busy, 0);

        // Basic poll
        push_txns(0, 16'h782D);
        push_status(16'h782D);
        enable = 1'b1;
        wait_status(1);

        // Busy retry: three busy CTRL reads, then ready
        c0 = n_ctrl_rd; d0 = n_data_rd;
        push_txns(3, 16'h782D);
        push_status(16'h782D);
        wait_status(2);
        chk("retry_ctrl_reads", n_ctrl_rd - c0, 4);
        chk("retry_data_reads", n_data_rd - d0, 1);

        // Link drop, then repeat of the same status
        push_txns(0, 16'h7849);
        push_status(16'h7849);
        wait_status(3);
        push_txns(0, 16'h7849);
        push_status(16'h7849);
        wait_status(4);

        // Busy timeout
        push_txn(1'b1, A_ADDR, 32'h0000_0401);
        push_txn(1'b1, A_CTRL, 32'h0000_0009);
        ctrl_wild        = 1'b1;
        ctrl_always_busy = 1'b1;
        d0 = n_data_rd;
        k  = 0;
        while (!err_timeout && k < 600) begin
            @(negedge clk);
            k++;
        end
        chk("err_timeout_set", err_timeout, 1);
        chk("tmo_phy_kept", phy_status, 16'h7849);
        chk("tmo_link_kept", link_up, 0);
        chk("tmo_busy_in_interval", busy, 0);
        chk("tmo_no_data_read", n_data_rd - d0, 0);
        ctrl_wild        = 1'b0;
        ctrl_always_busy = 1'b0;
        push_txns(0, 16'h782D);
        push_status(16'h782D);
        k = 0;
        while (!do_axi_write && k < 4 * POLL) begin
            @(negedge clk);
            k++;
        end
        chk("interval_length", k, POLL);
        wait_status(5);
        chk("err_timeout_sticky", err_timeout, 1);

        // Enable drop during W_WR_CTRL
        push_txns(0, 16'h782D);
        push_status(16'h782D);
        k = 0;
        while (!(do_axi_write && axi_write_addr == A_CTRL) && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("saw_ctrl_write", do_axi_write, 1);
        @(negedge clk);
        enable = 1'b0;
        wait_status(6);
        r0 = n_req;
        repeat (3 * POLL) @(negedge clk);
        chk("no_req_after_disable", n_req - r0, 0);
        chk("idle_after_disable", busy, 0);

        // Reset while waiting for the MDIO_RD read, late read_done after
        rd_delay = 8;
        push_txns(0, 16'h782D);
        enable = 1'b1;
        k = 0;
        while (!(do_axi_read && axi_read_addr == A_RD) && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("saw_data_read", do_axi_read, 1);
        @(negedge clk);
        rst    = 1'b1;
        enable = 1'b0;
        repeat (2) @(negedge clk);
        rst        = 1'b0;
        model_link = 1'b0;
        repeat (12) @(negedge clk);
        check_all_zero("post_rst");

        chk("txn_queue_drained", exp_txn_q.size(), 0);
        chk("status_queue_drained", exp_sts_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
